// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-FF synchroniser, mid-bit sampling and framing-error detection.
// Define UART_RX_MAJORITY_EN to take each sample as the 2-of-3 vote of the last three synchronised values.
module uart_rx #(
    parameter int BAUD_RATE  = 115200,
    parameter int CLOCK_FREQ = 10000000,
    parameter int NB_DATA_IN = 8,
    parameter int N_CYCLES   = 87
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_data,
    output logic [NB_DATA_IN-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);
    localparam int CW   = $clog2(N_CYCLES);
    localparam int BW   = NB_DATA_IN > 1 ? $clog2(NB_DATA_IN) : 1;
    localparam int HALF = N_CYCLES / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(N_CYCLES - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(NB_DATA_IN - 1);

    if (N_CYCLES < 8 || CLOCK_FREQ < BAUD_RATE) begin : g_bad_cfg
        $error("uart_rx: N_CYCLES must be >= 8 and CLOCK_FREQ >= BAUD_RATE");
    end

    typedef enum logic [2:0] {IDLE, START_BIT, DATA, STOP_BIT, WAIT_IDLE} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_idx;
    logic [NB_DATA_IN-1:0] shift;
    logic                  meta;
    logic                  rx_s;
    logic                  smp;

    always_ff @(posedge clock)
        meta <= reset ? 1'b1 : i_data;

`ifdef UART_RX_MAJORITY_EN
    // hist[0] is the synchronised line; hist[2:1] are the two preceding cycles
    logic [2:0] hist;
    always_ff @(posedge clock)
        hist <= reset ? 3'b111 : {hist[1:0], meta};
    assign rx_s = hist[0];
    assign smp  = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    always_ff @(posedge clock)
        rx_s <= reset ? 1'b1 : meta;
    assign smp = rx_s;
`endif

    assign o_busy = state != IDLE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START_BIT;
                end
                START_BIT:
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        state <= smp ? IDLE : DATA;
                    end else cnt <= cnt + 1'b1;
                DATA:
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shift[bit_idx] <= smp;
                        if (bit_idx == IDX_LAST) begin
                            bit_idx <= '0;
                            state   <= STOP_BIT;
                        end else bit_idx <= bit_idx + 1'b1;
                    end else cnt <= cnt + 1'b1;
                // leaving at mid-stop leaves half a bit to catch a back-to-back start edge
                STOP_BIT:
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (smp) begin
                            o_data  <= shift;
                            o_valid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else cnt <= cnt + 1'b1;
                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at default parameters.
module tb_uart_rx;
    localparam int N    = 87;
    localparam int HALF = N / 2;
    localparam int LAT  = 3 + HALF + 9 * N;
`ifdef UART_RX_MAJORITY_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_data = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_busy;

    int checks = 0, errors = 0;
    int cyc = 0, t0 = 0, vtime = 0;
    int vcnt = 0, ecnt = 0, both = 0, dbl = 0;
    logic pv = 1'b0, pe = 1'b0;
    logic [7:0] vq[$];
    int lat;

    uart_rx dut (
        .clock(clock), .reset(reset), .i_data(i_data),
        .o_data(o_data), .o_valid(o_valid), .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (o_valid) begin
            vcnt++;
            vq.push_back(o_data);
            vtime = cyc;
        end
        if (o_frame_err) ecnt++;
        if (o_valid && o_frame_err) both++;
        if ((o_valid && pv) || (o_frame_err && pe)) dbl++;
        pv = o_valid;
        pe = o_frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic b, input bit g);
        i_data = b;
        if (g) begin
            idle(HALF);
            i_data = ~b;
            idle(1);
            i_data = b;
            idle(N - HALF - 1);
        end else idle(N);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input bit g);
        t0 = cyc;
        drive(1'b0, g);
        for (int i = 0; i < 8; i++) drive(d[i], g);
        drive(stop, g);
    endtask

    initial begin
        // 1: reset with a toggling line
        for (int i = 0; i < 5; i++) begin
            i_data = ~i_data;
            idle(1);
        end
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ferr", o_frame_err, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        reset = 1'b0;
        i_data = 1'b1;
        idle(5);
        // 2: single frame and latency
        send(8'hA5, 1'b1, 1'b0);
        idle(10);
        lat = vtime - t0;
        chk("a5_count", vcnt, 1);
        chk("a5_q", vq[0], 8'hA5);
        chk("a5_data", o_data, 8'hA5);
        chk("a5_latency", (lat >= LAT - 1 && lat <= LAT + 1), 1);
        // 3: back-to-back frames
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(10);
        chk("b2b_count", vcnt, 3);
        chk("b2b_first", vq[1], 8'h00);
        chk("b2b_second", vq[2], 8'hFF);
        // 4: short low pulse is rejected as a false start
        i_data = 1'b0;
        idle(20);
        i_data = 1'b1;
        chk("glitch_busy_hi", o_busy, 1'b1);
        idle(HALF + 4 - 20);
        chk("glitch_busy_lo", o_busy, 1'b0);
        chk("glitch_no_valid", vcnt, 3);
        chk("glitch_no_ferr", ecnt, 0);
        // 5: framing error followed by a break, then recovery
        send(8'h3C, 1'b0, 1'b0);
        idle(300);
        chk("ferr_count", ecnt, 1);
        chk("ferr_no_valid", vcnt, 3);
        chk("ferr_data_kept", o_data, 8'hFF);
        chk("ferr_busy_break", o_busy, 1'b1);
        i_data = 1'b1;
        idle(5);
        chk("ferr_busy_release", o_busy, 1'b0);
        idle(10);
        send(8'h5A, 1'b1, 1'b0);
        idle(10);
        chk("recover_count", vcnt, 4);
        chk("recover_data", o_data, 8'h5A);
        // 6: reset in the middle of data bit 3
        i_data = 1'b0;
        idle(4 * N + HALF);
        reset = 1'b1;
        i_data = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
        chk("abort_data", o_data, 8'h00);
        chk("abort_busy", o_busy, 1'b0);
        idle(2 * N);
        chk("abort_no_valid", vcnt, 4);
        chk("abort_no_ferr", ecnt, 1);
        send(8'h81, 1'b1, GLITCH);
        idle(10);
        chk("post_abort_count", vcnt, 5);
        chk("post_abort_data", o_data, 8'h81);
        chk("valid_ferr_overlap", both, 0);
        chk("pulse_width", dbl, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
